pipe_stage_reg: RTL

Parametrised pipeline stage register: the generalised successor of the fixed ID/EX register, reusable at any stage boundary (IF/ID, ID/EX, EX/MEM). It carries an opaque payload of width DATA_W with a valid/ready handshake on both sides, so back-pressure stalls a stage without losing data. A controller hold level at or above FLUSH_LVL turns the stage into a bubble, as the existing stage registers do. An optional skid buffer gives full throughput with a registered ready_o.

---
 rtl/pipe_stage_reg.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised valid/ready pipeline stage register with flush-to-bubble.
// Define PIPE_SKID_EN for the 2-entry skid variant with a registered ready_o.
module pipe_stage_reg #(
   parameter int DATA_W    = 32,
   parameter int HOLD_W    = 3,
   parameter int FLUSH_LVL = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [HOLD_W-1:0] hold_flag_i,
   input  logic              valid_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              ready_o,
   output logic              valid_o,
   output logic [DATA_W-1:0] data_o,
   input  logic              ready_i
);

   localparam logic [31:0] FLUSH_LVL_U = 32'(FLUSH_LVL);

   logic              flush_s;
   logic              accept_s;
   logic              emit_s;
   logic              valid_r;
   logic [DATA_W-1:0] main_r;

   // Unsigned compare at 32 bits so an out-of-range FLUSH_LVL never truncates into a false match.
   assign flush_s = (32'(hold_flag_i) >= FLUSH_LVL_U);
   assign valid_o = valid_r;
   assign data_o  = main_r;

`ifdef PIPE_SKID_EN

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t            state_r;
   state_t            state_nx_s;
   logic              ready_r;
   logic [DATA_W-1:0] skid_r;
   logic [DATA_W-1:0] main_nx_s;
   logic [DATA_W-1:0] skid_nx_s;

   assign accept_s = valid_i & ready_r;
   assign emit_s   = valid_r & ready_i;
   assign ready_o  = ready_r;

   // Next-state and entry contents; flush overrides any handshake.
   always_comb begin
      state_nx_s = state_r;
      main_nx_s  = main_r;
      skid_nx_s  = skid_r;
      if (flush_s) begin
         state_nx_s = ST_EMPTY;
         main_nx_s  = {DATA_W{1'b0}};
         skid_nx_s  = {DATA_W{1'b0}};
      end else begin
         case (state_r)
            ST_EMPTY: begin
               if (accept_s) begin
                  state_nx_s = ST_BUSY;
                  main_nx_s  = data_i;
               end else begin
                  state_nx_s = ST_EMPTY;
               end
            end
            ST_BUSY: begin
               if (accept_s && emit_s) begin
                  main_nx_s = data_i;
               end else if (accept_s) begin
                  state_nx_s = ST_FULL;
                  skid_nx_s  = data_i;
               end else if (emit_s) begin
                  state_nx_s = ST_EMPTY;
                  main_nx_s  = {DATA_W{1'b0}};
               end else begin
                  state_nx_s = ST_BUSY;
               end
            end
            ST_FULL: begin
               if (emit_s) begin
                  state_nx_s = ST_BUSY;
                  main_nx_s  = skid_r;
                  skid_nx_s  = {DATA_W{1'b0}};
               end else begin
                  state_nx_s = ST_FULL;
               end
            end
            default: begin
               state_nx_s = ST_EMPTY;
               main_nx_s  = {DATA_W{1'b0}};
               skid_nx_s  = {DATA_W{1'b0}};
            end
         endcase
      end
   end

   // State and entry registers; valid/ready are flopped from the next state to keep ready_o registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_EMPTY;
         main_r  <= {DATA_W{1'b0}};
         skid_r  <= {DATA_W{1'b0}};
         valid_r <= 1'b0;
         ready_r <= 1'b1;
      end else begin
         state_r <= state_nx_s;
         main_r  <= main_nx_s;
         skid_r  <= skid_nx_s;
         valid_r <= (state_nx_s != ST_EMPTY);
         ready_r <= (state_nx_s != ST_FULL);
      end
   end

`else

   logic              valid_nx_s;
   logic [DATA_W-1:0] main_nx_s;

   assign ready_o  = ~valid_r | ready_i;
   assign accept_s = valid_i & ready_o;
   assign emit_s   = valid_r & ready_i;

   // Single entry: load on accept, clear to a bubble on emit without a replacement.
   always_comb begin
      valid_nx_s = valid_r;
      main_nx_s  = main_r;
      if (flush_s) begin
         valid_nx_s = 1'b0;
         main_nx_s  = {DATA_W{1'b0}};
      end else if (accept_s) begin
         valid_nx_s = 1'b1;
         main_nx_s  = data_i;
      end else if (emit_s) begin
         valid_nx_s = 1'b0;
         main_nx_s  = {DATA_W{1'b0}};
      end else begin
         valid_nx_s = valid_r;
         main_nx_s  = main_r;
      end
   end

   // Entry register.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_r <= 1'b0;
         main_r  <= {DATA_W{1'b0}};
      end else begin
         valid_r <= valid_nx_s;
         main_r  <= main_nx_s;
      end
   end

`endif

endmodule
